// File: rtl/set_assoc_cache_array.sv
// Set-associative tag/data array: registered lookup and victim query, tree pseudo-LRU,
// byte-masked stores, per-line invalidate and a one-set-per-cycle flush walk.
module set_assoc_cache_array #(
  parameter int NUM_WAYS   = 4,
  parameter int NUM_SETS   = 64,
  parameter int TAG_WIDTH  = 20,
  parameter int LINE_BYTES = 64,
  localparam int LINE_W = 8 * LINE_BYTES,
  localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
  localparam int SET_W  = $clog2(NUM_SETS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lookup_en,
  input  logic [SET_W-1:0]      lookup_set,
  input  logic [TAG_WIDTH-1:0]  lookup_tag,
  output logic                  lookup_valid,
  output logic                  lookup_hit,
  output logic [WAY_W-1:0]      lookup_hit_way,
  output logic [LINE_W-1:0]     lookup_data,
  input  logic                  fill_en,
  input  logic [SET_W-1:0]      fill_set,
  input  logic [WAY_W-1:0]      fill_way,
  input  logic [TAG_WIDTH-1:0]  fill_tag,
  input  logic [LINE_W-1:0]     fill_data,
  input  logic                  store_en,
  input  logic [SET_W-1:0]      store_set,
  input  logic [WAY_W-1:0]      store_way,
  input  logic [LINE_BYTES-1:0] store_be,
  input  logic [LINE_W-1:0]     store_data,
  input  logic                  inv_en,
  input  logic [SET_W-1:0]      inv_set,
  input  logic [WAY_W-1:0]      inv_way,
  input  logic                  victim_en,
  input  logic [SET_W-1:0]      victim_set,
  output logic [WAY_W-1:0]      victim_way,
  input  logic                  flush_start,
  output logic                  flush_busy,
  output logic                  flush_done
);

  localparam int LEVELS = $clog2(NUM_WAYS);
  localparam int PLRU_W = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1;

  typedef enum logic [1:0] {IDLE, WALK, DONE} flush_state_t;

  flush_state_t state_q;
  logic [SET_W-1:0] counter_q;
  logic flush_busy_q, flush_done_q;

  logic [NUM_WAYS-1:0]  valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0]  valid_d [NUM_SETS];
  logic [PLRU_W-1:0]    plru_q  [NUM_SETS];
  logic [PLRU_W-1:0]    plru_d  [NUM_SETS];
  logic [TAG_WIDTH-1:0] tag_mem [NUM_SETS][NUM_WAYS];
  logic [LINE_W-1:0]    data_mem[NUM_SETS][NUM_WAYS];

  logic lookup_valid_q, lookup_valid_d, lookup_hit_q, lookup_hit_d;
  logic [WAY_W-1:0] lookup_hit_way_q, lookup_hit_way_d, victim_way_q, victim_way_d;
  logic [LINE_W-1:0] lookup_data_q, lookup_data_d, store_line;
  logic raw_hit, wr_ok, fill_do, store_do, inv_do;
  logic [WAY_W-1:0] raw_way;

  // Heap-ordered tree: node n has children 2n+1 (left) and 2n+2 (right).
  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] tree,
                                                   input logic [WAY_W-1:0] way);
    logic [PLRU_W-1:0] t;
    int node;
    t = tree;
    node = 0;
    for (int l = 0; l < LEVELS; l++) begin
      t[node] = ~way[LEVELS-1-l];
      node = 2 * node + 1 + int'(way[LEVELS-1-l]);
    end
    return t;
  endfunction

  function automatic logic [WAY_W-1:0] pick_victim(input logic [NUM_WAYS-1:0] vld,
                                                   input logic [PLRU_W-1:0] tree);
    logic found;
    logic [WAY_W-1:0] first_free;
    int node, acc;
    found = 1'b0;
    first_free = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (!found && !vld[i]) begin
        found = 1'b1;
        first_free = WAY_W'(i);
      end
    end
    node = 0;
    acc = 0;
    for (int l = 0; l < LEVELS; l++) begin
      acc = 2 * acc + int'(tree[node]);
      node = 2 * node + 1 + int'(tree[node]);
    end
    return found ? first_free : WAY_W'(acc);
  endfunction

  assign wr_ok    = ~flush_busy_q;
  assign fill_do  = fill_en & wr_ok;
  assign inv_do   = inv_en & wr_ok;
  assign store_do = store_en & wr_ok &
                    ~(fill_en && fill_set == store_set && fill_way == store_way);

  always_comb begin
    raw_hit = 1'b0;
    raw_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[lookup_set][w] && tag_mem[lookup_set][w] == lookup_tag) begin
        raw_hit = 1'b1;
        raw_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    store_line = data_mem[store_set][store_way];
    for (int b = 0; b < LINE_BYTES; b++) begin
      if (store_be[b]) store_line[8*b +: 8] = store_data[8*b +: 8];
    end
  end

  // Hit touch first so a same-set fill touch overrides it; invalidate beats fill.
  always_comb begin
    valid_d = valid_q;
    plru_d  = plru_q;
    if (lookup_en && raw_hit && wr_ok)
      plru_d[lookup_set] = plru_touch(plru_d[lookup_set], raw_way);
    if (fill_do) begin
      plru_d[fill_set] = plru_touch(plru_d[fill_set], fill_way);
      valid_d[fill_set][fill_way] = 1'b1;
    end
    if (inv_do) valid_d[inv_set][inv_way] = 1'b0;
    if (state_q == WALK) begin
      valid_d[counter_q] = '0;
      plru_d[counter_q]  = '0;
    end
  end

  always_comb begin
    lookup_valid_d   = lookup_en;
    lookup_hit_d     = lookup_hit_q;
    lookup_hit_way_d = lookup_hit_way_q;
    lookup_data_d    = lookup_data_q;
    victim_way_d     = victim_way_q;
    if (lookup_en) begin
      lookup_hit_d     = raw_hit & wr_ok;
      lookup_hit_way_d = (raw_hit && wr_ok) ? raw_way : '0;
      lookup_data_d    = (raw_hit && wr_ok) ? data_mem[lookup_set][raw_way] : '0;
    end
    if (victim_en)
      victim_way_d = wr_ok ? pick_victim(valid_q[victim_set], plru_q[victim_set]) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
      lookup_valid_q   <= 1'b0;
      lookup_hit_q     <= 1'b0;
      lookup_hit_way_q <= '0;
      lookup_data_q    <= '0;
      victim_way_q     <= '0;
    end else begin
      valid_q          <= valid_d;
      plru_q           <= plru_d;
      lookup_valid_q   <= lookup_valid_d;
      lookup_hit_q     <= lookup_hit_d;
      lookup_hit_way_q <= lookup_hit_way_d;
      lookup_data_q    <= lookup_data_d;
      victim_way_q     <= victim_way_d;
    end
  end

  // Tag and data storage carries no reset; valid bits decide what is meaningful.
  always_ff @(posedge clk) begin
    if (fill_do) begin
      tag_mem[fill_set][fill_way]  <= fill_tag;
      data_mem[fill_set][fill_way] <= fill_data;
    end
    if (store_do) data_mem[store_set][store_way] <= store_line;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      counter_q    <= '0;
      flush_busy_q <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (flush_start) begin
          state_q      <= WALK;
          counter_q    <= '0;
          flush_busy_q <= 1'b1;
        end
        WALK: if (counter_q == SET_W'(NUM_SETS - 1)) begin
          state_q      <= DONE;
          flush_done_q <= 1'b1;
        end else begin
          counter_q <= counter_q + 1'b1;
        end
        DONE: begin
          state_q      <= IDLE;
          flush_busy_q <= 1'b0;
          flush_done_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lookup_valid   = lookup_valid_q;
  assign lookup_hit     = lookup_hit_q;
  assign lookup_hit_way = lookup_hit_way_q;
  assign lookup_data    = lookup_data_q;
  assign victim_way     = victim_way_q;
  assign flush_busy     = flush_busy_q;
  assign flush_done     = flush_done_q;

endmodule

// File: tb/tb_set_assoc_cache_array.sv
// Randomised and directed bench for set_assoc_cache_array against an array-level model
// whose PLRU state is kept as one direction bit per (level, subtree prefix).
module tb_set_assoc_cache_array;

  localparam int WAYS = 4, SETS = 64, TW = 20, LB = 64, LW = 512, WW = 2, SW = 6, LEVELS = 2;

  logic clk = 1'b0, rst = 1'b1;
  logic lookup_en = 1'b0, fill_en = 1'b0, store_en = 1'b0, inv_en = 1'b0;
  logic victim_en = 1'b0, flush_start = 1'b0;
  logic [SW-1:0] lookup_set = '0, fill_set = '0, store_set = '0, inv_set = '0, victim_set = '0;
  logic [WW-1:0] fill_way = '0, store_way = '0, inv_way = '0;
  logic [TW-1:0] lookup_tag = '0, fill_tag = '0;
  logic [LW-1:0] fill_data = '0, store_data = '0;
  logic [LB-1:0] store_be = '0;
  logic lookup_valid, lookup_hit, flush_busy, flush_done;
  logic [WW-1:0] lookup_hit_way, victim_way;
  logic [LW-1:0] lookup_data;

  set_assoc_cache_array dut (
    .clk(clk), .rst(rst),
    .lookup_en(lookup_en), .lookup_set(lookup_set), .lookup_tag(lookup_tag),
    .lookup_valid(lookup_valid), .lookup_hit(lookup_hit),
    .lookup_hit_way(lookup_hit_way), .lookup_data(lookup_data),
    .fill_en(fill_en), .fill_set(fill_set), .fill_way(fill_way),
    .fill_tag(fill_tag), .fill_data(fill_data),
    .store_en(store_en), .store_set(store_set), .store_way(store_way),
    .store_be(store_be), .store_data(store_data),
    .inv_en(inv_en), .inv_set(inv_set), .inv_way(inv_way),
    .victim_en(victim_en), .victim_set(victim_set), .victim_way(victim_way),
    .flush_start(flush_start), .flush_busy(flush_busy), .flush_done(flush_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;

  // Reference state
  bit            m_valid[SETS][WAYS];
  logic [TW-1:0] m_tag[SETS][WAYS];
  logic [LW-1:0] m_data[SETS][WAYS];
  bit            m_tree[SETS][LEVELS][WAYS];
  int            m_phase = 0, m_cnt = 0;
  logic          exp_valid, exp_hit, exp_busy, exp_done;
  logic [WW-1:0] exp_way, exp_victim;
  logic [LW-1:0] exp_data;

  task automatic checkOutput(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelTouch(input int s, input int w);
    for (int l = 0; l < LEVELS; l++)
      m_tree[s][l][w >> (LEVELS - l)] = (((w >> (LEVELS - 1 - l)) & 1) == 0);
  endtask

  function automatic int modelVictim(input int s);
    int p;
    for (int w = 0; w < WAYS; w++) if (!m_valid[s][w]) return w;
    p = 0;
    for (int l = 0; l < LEVELS; l++) p = 2 * p + int'(m_tree[s][l][p]);
    return p;
  endfunction

  task automatic modelLookup(input int s, input logic [TW-1:0] t, output bit h, output int hw);
    h = 0;
    hw = 0;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == t) begin
        h = 1;
        hw = w;
      end
  endtask

  function automatic logic [LW-1:0] randLine();
    logic [LW-1:0] r;
    for (int i = 0; i < LW / 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // One clock with the currently driven inputs, then compare every output with the model
  task automatic applyStimulus();
    bit busy, h;
    int hw, ls, fs, fw, ss, sw;
    busy = (m_phase != 0);
    ls = int'(lookup_set); fs = int'(fill_set); fw = int'(fill_way);
    ss = int'(store_set); sw = int'(store_way);
    if (rst) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) begin
          m_valid[s][w] = 0;
          for (int l = 0; l < LEVELS; l++) m_tree[s][l][w] = 0;
        end
      m_phase = 0; m_cnt = 0;
      exp_valid = 0; exp_hit = 0; exp_way = '0; exp_data = '0; exp_victim = '0;
    end else begin
      modelLookup(ls, lookup_tag, h, hw);
      exp_valid = lookup_en;
      if (lookup_en) begin
        exp_hit  = h && !busy;
        exp_way  = (h && !busy) ? WW'(hw) : '0;
        exp_data = (h && !busy) ? m_data[ls][hw] : '0;
      end
      if (victim_en) exp_victim = busy ? '0 : WW'(modelVictim(int'(victim_set)));
      if (!busy) begin
        if (lookup_en && h) modelTouch(ls, hw);
        if (store_en && !(fill_en && fs == ss && fw == sw))
          for (int b = 0; b < LB; b++)
            if (store_be[b]) m_data[ss][sw][8*b +: 8] = store_data[8*b +: 8];
        if (fill_en) begin
          modelTouch(fs, fw);
          m_valid[fs][fw] = 1;
          m_tag[fs][fw] = fill_tag;
          m_data[fs][fw] = fill_data;
        end
        if (inv_en) m_valid[int'(inv_set)][int'(inv_way)] = 0;
      end
      case (m_phase)
        0: if (flush_start) begin m_phase = 1; m_cnt = 0; end
        1: begin
          for (int w = 0; w < WAYS; w++) begin
            m_valid[m_cnt][w] = 0;
            for (int l = 0; l < LEVELS; l++) m_tree[m_cnt][l][w] = 0;
          end
          if (m_cnt == SETS - 1) m_phase = 2; else m_cnt++;
        end
        default: m_phase = 0;
      endcase
    end
    exp_busy = (m_phase != 0);
    exp_done = (m_phase == 2);
    @(posedge clk);
    #1;
    checkOutput("lookup_valid", LW'(lookup_valid), LW'(exp_valid));
    checkOutput("lookup_hit", LW'(lookup_hit), LW'(exp_hit));
    checkOutput("lookup_hit_way", LW'(lookup_hit_way), LW'(exp_way));
    checkOutput("lookup_data", lookup_data, exp_data);
    checkOutput("victim_way", LW'(victim_way), LW'(exp_victim));
    checkOutput("flush_busy", LW'(flush_busy), LW'(exp_busy));
    checkOutput("flush_done", LW'(flush_done), LW'(exp_done));
  endtask

  task automatic clearInputs();
    lookup_en = 0; fill_en = 0; store_en = 0; inv_en = 0; victim_en = 0; flush_start = 0;
  endtask

  task automatic doFill(input int s, input int w, input logic [TW-1:0] t, input logic [LW-1:0] d);
    fill_en = 1; fill_set = SW'(s); fill_way = WW'(w); fill_tag = t; fill_data = d;
    applyStimulus();
    clearInputs();
  endtask

  task automatic doLookup(input int s, input logic [TW-1:0] t);
    lookup_en = 1; lookup_set = SW'(s); lookup_tag = t;
    applyStimulus();
    clearInputs();
  endtask

  task automatic doVictim(input int s);
    victim_en = 1; victim_set = SW'(s);
    applyStimulus();
    clearInputs();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [LW-1:0] pattern;
    int busy_cnt, done_cnt;

    #1;
    applyStimulus();
    applyStimulus();
    checkOutput("rst_lookup_valid", LW'(lookup_valid), '0);
    checkOutput("rst_flush_busy", LW'(flush_busy), '0);
    rst = 0;

    for (int i = 0; i < 16; i++) pattern[32*i +: 32] = 32'h7114C100;
    doFill(5, 2, 20'h8C7C4, pattern);
    doLookup(5, 20'h8C7C4);
    checkOutput("dir_hit", LW'(lookup_hit), LW'(1));
    checkOutput("dir_hit_way", LW'(lookup_hit_way), LW'(2));
    checkOutput("dir_hit_data", lookup_data, pattern);
    doLookup(5, 20'h9CDFA);
    checkOutput("dir_miss", LW'(lookup_hit), '0);
    checkOutput("dir_miss_data", lookup_data, '0);

    doVictim(3);
    checkOutput("victim_empty", LW'(victim_way), '0);
    for (int w = 0; w < WAYS; w++) doFill(3, w, TW'(20'h300 + w), randLine());
    doVictim(3);
    checkOutput("victim_full", LW'(victim_way), '0);
    doLookup(3, 20'h300);
    doVictim(3);
    checkOutput("victim_after_hit0", LW'(victim_way), LW'(2));
    doLookup(3, 20'h302);
    doVictim(3);
    checkOutput("victim_after_hit2", LW'(victim_way), LW'(1));

    doFill(7, 1, 20'h00007, '0);
    store_en = 1; store_set = 7; store_way = 1; store_be = 64'h3; store_data = '1;
    applyStimulus();
    clearInputs();
    doLookup(7, 20'h00007);
    checkOutput("store_merge", lookup_data, LW'(16'hFFFF));

    lookup_en = 1; lookup_set = 9; lookup_tag = 20'h12763;
    fill_en = 1; fill_set = 9; fill_way = 0; fill_tag = 20'h12763; fill_data = randLine();
    applyStimulus();
    clearInputs();
    checkOutput("collide_miss", LW'(lookup_hit), '0);
    doLookup(9, 20'h12763);
    checkOutput("collide_later_hit", LW'(lookup_hit), LW'(1));
    inv_en = 1; inv_set = 9; inv_way = 0;
    fill_en = 1; fill_set = 9; fill_way = 0; fill_tag = 20'h12763; fill_data = randLine();
    applyStimulus();
    clearInputs();
    doLookup(9, 20'h12763);
    checkOutput("inv_fill_miss", LW'(lookup_hit), '0);

    // Random traffic on a few sets with a small tag pool so hits are frequent
    for (int i = 0; i < 1500; i++) begin
      lookup_en = 1'($urandom_range(0, 1));
      lookup_set = SW'($urandom_range(0, 3));
      lookup_tag = TW'($urandom_range(0, 15));
      fill_en = ($urandom_range(0, 3) == 0);
      fill_set = SW'($urandom_range(0, 3));
      fill_way = WW'($urandom_range(0, 3));
      fill_tag = TW'(($urandom_range(0, 3) << 2) | int'(fill_way));
      fill_data = randLine();
      store_en = ($urandom_range(0, 3) == 0);
      store_set = SW'($urandom_range(0, 3));
      store_way = WW'($urandom_range(0, 3));
      store_be = {$urandom, $urandom};
      store_data = randLine();
      inv_en = ($urandom_range(0, 7) == 0);
      inv_set = SW'($urandom_range(0, 3));
      inv_way = WW'($urandom_range(0, 3));
      victim_en = 1'($urandom_range(0, 1));
      victim_set = SW'($urandom_range(0, 3));
      flush_start = ($urandom_range(0, 299) == 0);
      applyStimulus();
    end
    clearInputs();
    for (int i = 0; i < 200 && m_phase != 0; i++) applyStimulus();
    checkOutput("idle_after_random", LW'(flush_busy), '0);

    for (int s = 20; s < 24; s++) doFill(s, 0, TW'(s), randLine());
    flush_start = 1;
    applyStimulus();
    clearInputs();
    busy_cnt = int'(flush_busy);
    done_cnt = int'(flush_done);
    for (int i = 0; i < 100 && flush_busy; i++) begin
      if (i == 20) begin
        fill_en = 1; fill_set = 30; fill_way = 0; fill_tag = 20'h55; fill_data = randLine();
      end
      applyStimulus();
      clearInputs();
      busy_cnt += int'(flush_busy);
      done_cnt += int'(flush_done);
    end
    checkOutput("flush_busy_len", LW'(busy_cnt), LW'(65));
    checkOutput("flush_done_cnt", LW'(done_cnt), LW'(1));
    for (int s = 20; s < 24; s++) begin
      doLookup(s, TW'(s));
      checkOutput("post_flush_miss", LW'(lookup_hit), '0);
    end
    doLookup(30, 20'h55);
    checkOutput("midflush_fill_dropped", LW'(lookup_hit), '0);
    doLookup(5, 20'h8C7C4);
    checkOutput("post_flush_miss5", LW'(lookup_hit), '0);
    doVictim(3);
    checkOutput("post_flush_victim3", LW'(victim_way), '0);
    doVictim(20);
    checkOutput("post_flush_victim20", LW'(victim_way), '0);

    doFill(40, 1, 20'h41, randLine());
    flush_start = 1;
    applyStimulus();
    clearInputs();
    repeat (10) applyStimulus();
    rst = 1;
    applyStimulus();
    rst = 0;
    checkOutput("rst_mid_flush_busy", LW'(flush_busy), '0);
    done_cnt = int'(flush_done);
    for (int i = 0; i < 70; i++) begin
      applyStimulus();
      done_cnt += int'(flush_done);
    end
    checkOutput("rst_mid_flush_no_done", LW'(done_cnt), '0);
    doLookup(40, 20'h41);
    checkOutput("rst_mid_flush_miss", LW'(lookup_hit), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/set_assoc_cache_array.md
# set_assoc_cache_array

Parametrised set-associative tag/data array with a registered one-cycle lookup, victim selection (invalid-first, then tree pseudo-LRU), per-byte store merge, per-line invalidate and a sequenced flush-all. It is the next-generation array behind the L1 instruction and data caches. The cache control pipelines sit above it and own the miss handling. It is generic in ways, sets, tag width and line size.

## Interface
- NUM_WAYS, 4, associativity; power of two, 1..8
- NUM_SETS, 64, sets; power of two, >= 2
- TAG_WIDTH, 20, stored tag bits
- LINE_BYTES, 64, bytes per line; LINE_W = 8*LINE_BYTES, WAY_W = max(1, log2 NUM_WAYS), SET_W = log2 NUM_SETS
- clk  in  1  sole clock, rising edge
- rst  in  1  one clock; reset is synchronous and active-high
- lookup_en / lookup_set / lookup_tag  in  1 / SET_W / TAG_WIDTH  lookup request
- lookup_valid  out  1  registered echo of lookup_en
- lookup_hit / lookup_hit_way / lookup_data  out  1 / WAY_W / LINE_W  lookup result
- fill_en / fill_set / fill_way / fill_tag / fill_data  in  1 / SET_W / WAY_W / TAG_WIDTH / LINE_W  full-line install
- store_en / store_set / store_way / store_be / store_data  in  1 / SET_W / WAY_W / LINE_BYTES / LINE_W  byte-masked data write
- inv_en / inv_set / inv_way  in  1 / SET_W / WAY_W  clear one valid bit
- victim_en / victim_set  in  1 / SET_W  victim query
- victim_way  out  WAY_W  registered victim
- flush_start  in  1  begin flush-all
- flush_busy / flush_done  out  1 / 1  flush in progress / one-cycle completion pulse

## Operation
- State per set: valid[NUM_WAYS], tag[NUM_WAYS], data[NUM_WAYS], plru[NUM_WAYS-1]. Valid and plru are reset. Tag and data are not reset.
- Lookup: hit when some way has valid and a matching tag. hit_way is that way; tags are unique per set by contract. lookup_data is the hit way's line. On a miss, lookup_data = 0 and hit_way = 0.
- Victim: lowest-index invalid way of victim_set. If all ways are valid, the tree-PLRU way: walk from the root, bit 0 → left subtree, bit 1 → right. NUM_WAYS = 1 → always 0.
- PLRU touch on way w sets each node on w's path to point away from w.
- Touches happen on a fill (fill_way) and on a lookup hit (hit_way, applied at the edge that registers the hit).
- Same set, same cycle: the fill touch is applied after the hit touch, so the fill wins.
- Fill: writes tag, data and valid=1.
- Store: writes bytes b where store_be[b] = 1, i.e. data[8b+7:8b]. Valid and tag are unchanged.
- Store is performed regardless of valid; the caller guarantees a hit.
- Same set and way, same cycle: inv > fill > store.
  - inv + fill leaves the line invalid, with the tag and data written.
  - fill + store writes fill_data only.
- Flush FSM, IDLE → WALK → DONE → IDLE:
  - flush_start in IDLE enters WALK with counter = 0.
  - WALK clears all valid bits and all PLRU bits of set `counter` each cycle, then increments.
  - counter = NUM_SETS-1 → DONE, which pulses flush_done for one cycle and returns to IDLE.
  - flush_start outside IDLE is ignored.
- While flush_busy: fill, store, inv and the PLRU touches are dropped. lookup_hit = 0. victim_way = 0.

## Timing
- Reset (rst high at an edge): all valid = 0, all plru = 0, flush FSM = IDLE, counter = 0.
- Reset values of outputs: lookup_valid, lookup_hit, lookup_hit_way, lookup_data, victim_way, flush_busy and flush_done are all 0.
- Reset mid-flush aborts the flush with no flush_done.
- Lookup latency 1: request at edge N, result valid after edge N (visible in cycle N+1). Outputs hold until the next request.
- Victim latency 1, same as lookup.
- Writes commit at edge N and are visible to a lookup presented at edge N+1.
- A lookup or victim query at the same edge as a write to the same set sees pre-write state (read-before-write, no bypass).
- flush_busy is high from the cycle after flush_start through DONE, i.e. NUM_SETS+1 cycles.
- flush_done is high in the DONE cycle only.
- No back-pressure: every request is accepted every cycle.

## Test plan
- Directed cases use the defaults (4 ways, 64 sets).
- Fill then lookup:
  - fill set 5 way 2, tag 0x8C7C4, data {16{0x7114C100}}; lookup set 5 tag 0x8C7C4 next cycle → hit = 1, way = 2, data matches.
  - Lookup tag 0x9CDFA → hit = 0, data = 0.
- Victim order:
  - on an empty set 3, victim → 0.
  - Fill ways 0,1,2,3 in order → victim → 0.
  - Then hit on way 0 → victim → 2.
  - Then hit on way 2 → victim → 1.
- Byte store:
  - fill set 7 way 1 with all 0x00.
  - store_be = 0x0000_0000_0000_0003, data all 0xFF → lookup returns 0xFFFF in bytes 1..0 and 0 elsewhere.
- Collision:
  - lookup and fill of set 9 way 0 tag 0x12763 at the same edge → miss; the same lookup one cycle later → hit.
  - inv + fill of the same line at the same edge → a later lookup misses.
- Flush:
  - fill 4 sets.
  - Pulse flush_start → flush_busy is high for 65 cycles and flush_done pulses once.
  - A fill issued mid-flush is dropped.
  - All lookups miss afterwards, and victim on any set → 0.
- Reset mid-flush: assert rst 10 cycles into WALK → flush_busy = 0 next cycle, no flush_done, all lookups miss.
